// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, data width and bit-timing helpers.
// Used by both the receiver and the transmitter.
package uart_pkg;

   localparam int unsigned UART_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   function automatic int unsigned calc_bit_cnt(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
      return clk_freq / baud_rate;
   endfunction

   function automatic int unsigned calc_half_cnt(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
      return (clk_freq / baud_rate) / 2;
   endfunction

endpackage

// File: rtl/uart_rxd_ovs_if.sv
// Parallel-side bundle of the UART receiver: received byte plus status strobes.
interface uart_rxd_ovs_if;
   import uart_pkg::*;

   logic [UART_DATA_W-1:0] O_para_data;
   logic                   O_rx_done;
   logic                   O_frame_err;
   logic                   O_rx_busy;

   modport master (
      output O_para_data,
      output O_rx_done,
      output O_frame_err,
      output O_rx_busy
   );

   modport slave (
      input O_para_data,
      input O_rx_done,
      input O_frame_err,
      input O_rx_busy
   );

endinterface

// File: rtl/uart_rx_sync.sv
// RXD input conditioning: 2-flop synchroniser, history flop, falling-edge detect.
// UART_RX_MAJORITY_EN selects a 2-of-3 majority sample over the last three cycles.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rxd_i,
   output logic sample_o,
   output logic fall_o
);

   logic       s1_q, s1_d;
   logic       s2_q, s2_d;
   logic       hist_q, hist_d;
   logic [2:0] fill_q, fill_d;
`ifdef UART_RX_MAJORITY_EN
   logic       tap1_q, tap1_d;
   logic       tap2_q, tap2_d;
`endif

   always_comb begin
      s1_d   = rxd_i;
      s2_d   = s1_q;
      hist_d = s2_q;
      fill_d = {fill_q[1:0], 1'b1};
   end

   // The pipeline comes out of reset holding 1s, not real line values; a low
   // line at reset release would otherwise look like a start edge.
   always_comb begin
      fall_o = fill_q[2] & hist_q & ~s2_q;
   end

`ifdef UART_RX_MAJORITY_EN
   always_comb begin
      tap1_d   = s2_q;
      tap2_d   = tap1_q;
      sample_o = (s2_q & tap1_q) | (s2_q & tap2_q) | (tap1_q & tap2_q);
   end
`else
   always_comb begin
      sample_o = s2_q;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q   <= 1'b1;
         s2_q   <= 1'b1;
         hist_q <= 1'b1;
         fill_q <= '0;
`ifdef UART_RX_MAJORITY_EN
         tap1_q <= 1'b1;
         tap2_q <= 1'b1;
`endif
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
`ifdef UART_RX_MAJORITY_EN
         tap1_q <= tap1_d;
         tap2_q <= tap2_d;
`endif
      end
   end

endmodule

// File: rtl/uart_rxd_ovs.sv
// 8N1 UART receiver with internal bit timing from a clock-cycle counter.
// Optional macro UART_RX_MAJORITY_EN enables 2-of-3 majority sampling.
module uart_rxd_ovs
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned BAUD_RATE = 9600
) (
   input  logic             I_clk,
   input  logic             I_rst,
   input  logic             I_rs232_rxd,
   uart_rxd_ovs_if.master   rx_if
);

   localparam int unsigned BIT_CNT  = calc_bit_cnt(CLK_FREQ, BAUD_RATE);
   localparam int unsigned HALF_CNT = calc_half_cnt(CLK_FREQ, BAUD_RATE);
   localparam int unsigned CNT_W    = $clog2(BIT_CNT);

   localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(BIT_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_CNT - 1);

   uart_state_e            state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [2:0]             idx_q, idx_d;
   logic [UART_DATA_W-1:0] shift_q, shift_d;
   logic [UART_DATA_W-1:0] data_q, data_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;

   logic                   rx_sample;
   logic                   rx_fall;

   uart_rx_sync u_sync (
      .clk      (I_clk),
      .rst      (I_rst),
      .rxd_i    (I_rs232_rxd),
      .sample_o (rx_sample),
      .fall_o   (rx_fall)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (rx_fall) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (cnt_q == CNT_HALF_END) begin
               cnt_d = '0;
               idx_d = '0;
               state_d = rx_sample ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt_q == CNT_BIT_END) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_sample;
               if (idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         ST_STOP: begin
            // Leaving at the stop-bit midpoint leaves half a bit to catch the next start edge.
            if (cnt_q == CNT_BIT_END) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
               if (rx_sample) begin
                  done_d = 1'b1;
                  data_d = shift_q;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      rx_if.O_para_data = data_q;
      rx_if.O_rx_done   = done_q;
      rx_if.O_frame_err = err_q;
      rx_if.O_rx_busy   = (state_q != ST_IDLE);
   end

endmodule

// File: doc/uart_rxd_ovs.md
# uart_rxd_ovs

Serial receive side of the RS-232 link: samples the asynchronous RXD pin against the 50 MHz system clock, recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) and presents each byte as a parallel word with a one-cycle done strobe. It generates its own bit timing from a clock-cycle counter, so it needs no external baud-rate block. It sits between the board RXD pin and the command/data consumer, pairing with the existing transmitter.

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- BAUD_RATE, 9600, line rate in bit/s; BIT_CNT = CLK_FREQ/BAUD_RATE (integer), HALF_CNT = BIT_CNT/2; BIT_CNT >= 4 required
- I_clk  in  1  system clock; all logic on rising edge
- I_rst  in  1  reset, synchronous, active-high
- I_rs232_rxd  in  1  asynchronous serial input, idle high
- O_para_data  out  8  last correctly framed byte; holds until next good frame
- O_rx_done  out  1  one-cycle pulse: O_para_data updated this cycle
- O_frame_err  out  1  one-cycle pulse: stop bit sampled low, byte discarded
- O_rx_busy  out  1  high while state != IDLE

## Operation
- Input path: 2-flop synchroniser plus one history flop, all reset to 1. Falling edge = history 1 and sync 0.
- States: IDLE, START, DATA, STOP. Bit counter cnt (width ceil(log2 BIT_CNT)), bit index idx (3 bits), 8-bit shift register.
- IDLE: on falling edge -> START, cnt=0. Line low without an edge (break, reset release mid-frame) does not start reception.
- START: when cnt == HALF_CNT-1, sample. Low -> DATA, cnt=0, idx=0. High (glitch) -> IDLE, no output pulses.
- DATA: when cnt == BIT_CNT-1, sample, shift into bit idx (LSB first), cnt=0; after idx 7 -> STOP.
- STOP: when cnt == BIT_CNT-1, sample. High -> O_para_data <= shift register, O_rx_done=1, -> IDLE. Low -> O_frame_err=1, O_para_data unchanged, -> IDLE (next frame requires the line high, then a falling edge).
- O_rx_done and O_frame_err are never high together.
- Reset values: O_para_data=0, O_rx_done=0, O_frame_err=0, O_rx_busy=0, state IDLE, cnt/idx/shift=0.
- Reset mid-frame: next cycle IDLE, partial byte discarded, no pulses.

## Timing
- Pin to START entry: 3 cycles (2 sync + edge detect).
- Start sample: HALF_CNT cycles after START entry. Data bit k sample: HALF_CNT + (k+1)*BIT_CNT cycles after START entry. Stop sample: HALF_CNT + 9*BIT_CNT.
- O_rx_done / O_frame_err: high exactly the cycle after the stop sample, for 1 cycle; O_rx_busy falls in that same cycle.
- Back-to-back frames: IDLE is reached about half a bit before the stop-bit end, so the next start edge is always caught. No inter-frame gap needed.
- Tolerated baud mismatch: ±4 % total.

## Configuration
- UART_RX_MAJORITY_EN defined: every sample (start, data, stop) is the 2-of-3 majority of the synchronised line at counts C-2, C-1, C, where C is the sample count; needs 2 extra history flops. Single-cycle glitches at the sample point are rejected.
- Not defined: single sample at count C. Timing above is identical in both builds.

## Structure
- Shared package uart_pkg: state encoding localparams (IDLE/START/DATA/STOP), UART_DATA_W=8, function computing BIT_CNT/HALF_CNT from CLK_FREQ/BAUD_RATE; also used by the transmitter.
- One sub-module: uart_rx_sync (synchroniser, history flops, falling-edge detect, optional majority taps).

## Test plan
All scenarios use CLK_FREQ=160, BAUD_RATE=10 (BIT_CNT=16, HALF_CNT=8).
- Frame 0x55, 1 stop bit -> O_para_data=0x55, O_rx_done 1 cycle at START+8+144+1, O_frame_err 0.
- Back-to-back 0xA3 then 0x0F, no gap -> two O_rx_done pulses 160 cycles apart, data 0xA3 then 0x0F.
- RXD low for 4 cycles, then high -> START then IDLE, O_rx_busy low again, no done/err pulses.
- After 0x12 received, send 0xFF with stop bit 0 -> O_frame_err pulse, O_para_data stays 0x12; line held low 40 cycles, then high, then frame 0x34 -> 0x34 received.
- I_rst high 1 cycle during data bit 3 -> all outputs 0 next cycle. Release with line low -> no reception. Line high, then frame 0x3C -> 0x3C received.
- Frame 0x00 with a 1-cycle high glitch at bit-2 sample point -> with UART_RX_MAJORITY_EN: 0x00. Without it: 0x04.
